instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/fetch_pkg.sv | 26 ++
 rtl/instr_predecode.sv | 36 +++
 rtl/instr_fetch.sv | 131 +++++++++++++
 tb/tb_instr_fetch.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction fetch stage: opcode constants used
// by the predecoder, the instruction/index width, and the fetch FSM states.
// No ports; imported by instr_predecode and instr_fetch.
// ---------------------------------------------------------------------------
package fetch_pkg;

  localparam int XLEN = 32;

  localparam logic [5:0] OPC_J   = 6'b000010;
  localparam logic [5:0] OPC_BEQ = 6'b000100;

  typedef enum logic [1:0] {
    START = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2
  } fetch_state_e;

  // Reduces a word index to the implemented memory range.
  function automatic logic [XLEN-1:0] maskIndex(input logic [XLEN-1:0] idx,
                                                input logic [XLEN-1:0] mask);
    return idx & mask;
  endfunction

endpackage

// File: rtl/instr_predecode.sv
// ---------------------------------------------------------------------------
// instr_predecode
// Purely combinational look at the instruction currently being read from
// the instruction memory, so the fetch stage can follow unconditional jumps
// without inserting a bubble.
//
// Ports:
//   instr_i        instruction word read at pc_i
//   pc_i           word index the instruction was read from
//   is_jump_o      instruction is a j (opcode OPC_J)
//   jump_target_o  j target field, reduced to the memory index range
//   pc_plus1_o     pc_i + 1, wrapping at IMEM_DEPTH
//   next_pc_o      index to fetch after this instruction
// ---------------------------------------------------------------------------
module instr_predecode
  import fetch_pkg::*;
#(
  parameter int IMEM_DEPTH = 16
) (
  input  logic [XLEN-1:0] instr_i,
  input  logic [XLEN-1:0] pc_i,
  output logic            is_jump_o,
  output logic [XLEN-1:0] jump_target_o,
  output logic [XLEN-1:0] pc_plus1_o,
  output logic [XLEN-1:0] next_pc_o
);

  // IMEM_DEPTH is a power of two, so depth-1 is an all-ones index mask.
  localparam logic [XLEN-1:0] IDX_MASK = XLEN'(IMEM_DEPTH - 1);

  assign is_jump_o     = (instr_i[31:26] == OPC_J);
  assign jump_target_o = maskIndex({6'b000000, instr_i[25:0]}, IDX_MASK);
  assign pc_plus1_o    = maskIndex(pc_i + 32'd1, IDX_MASK);
  assign next_pc_o     = is_jump_o ? jump_target_o : pc_plus1_o;

endmodule

// File: rtl/instr_fetch.sv
// ---------------------------------------------------------------------------
// instr_fetch
// Single-entry instruction fetch stage. Holds the PC, reads the instruction
// memory combinationally, and captures one instruction per cycle into an
// output register with a valid/ready handshake. Unconditional jumps are
// followed in the same cycle they are fetched; a redirect from execute
// overrides everything except reset and discards any held entry.
//
// Ports:
//   clk              clock, rising edge
//   reset            synchronous active-high reset
//   imem_index       word index presented to the instruction memory (= PC)
//   imem_instr       instruction word at imem_index, same cycle
//   redirect_valid   taken-branch redirect request
//   redirect_target  word index to fetch next on redirect
//   out_valid        output register holds a valid entry
//   out_ready        downstream accepts the entry this cycle
//   out_instr        fetched instruction
//   out_pc           word index of the fetched instruction
//   out_pc_plus1     out_pc + 1, wrapping at IMEM_DEPTH
// ---------------------------------------------------------------------------
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int IMEM_DEPTH = 16,
  parameter int RESET_PC   = 0
) (
  input  logic            clk,
  input  logic            reset,
  output logic [XLEN-1:0] imem_index,
  input  logic [XLEN-1:0] imem_instr,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_pc_plus1
);

  localparam logic [XLEN-1:0] IDX_MASK  = XLEN'(IMEM_DEPTH - 1);
  localparam logic [XLEN-1:0] RESET_IDX = XLEN'(RESET_PC) & IDX_MASK;

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] out_instr_q, out_instr_d;
  logic [XLEN-1:0] out_pc_q, out_pc_d;
  logic [XLEN-1:0] out_pc_plus1_q, out_pc_plus1_d;

  logic            is_jump;
  logic [XLEN-1:0] jump_target;
  logic [XLEN-1:0] pc_plus1;
  logic [XLEN-1:0] next_pc;

  instr_predecode #(
    .IMEM_DEPTH (IMEM_DEPTH)
  ) u_predecode (
    .instr_i       (imem_instr),
    .pc_i          (pc_q),
    .is_jump_o     (is_jump),
    .jump_target_o (jump_target),
    .pc_plus1_o    (pc_plus1),
    .next_pc_o     (next_pc)
  );

  // Next-state logic. A redirect wins over capture, stall and jump
  // predecode in every state. Otherwise the output register accepts a new
  // instruction whenever it is empty or being drained this cycle, which
  // gives one instruction per cycle under continuous ready. When the entry
  // is held and not accepted, nothing (PC included) moves.
  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    out_valid_d    = out_valid_q;
    out_instr_d    = out_instr_q;
    out_pc_d       = out_pc_q;
    out_pc_plus1_d = out_pc_plus1_q;

    if (redirect_valid) begin
      pc_d        = maskIndex(redirect_target, IDX_MASK);
      out_valid_d = 1'b0;
      state_d     = RUN;
    end else begin
      case (state_q)
        START: begin
          state_d = RUN;
        end
        RUN, STALL: begin
          if (!out_valid_q || out_ready) begin
            out_instr_d    = imem_instr;
            out_pc_d       = pc_q;
            out_pc_plus1_d = pc_plus1;
            out_valid_d    = 1'b1;
            pc_d           = next_pc;
          end
          state_d = (out_valid_q && !out_ready) ? STALL : RUN;
        end
        default: begin
          state_d = START;
        end
      endcase
    end
  end

  // State and output registers. Reset overrides redirect and stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= START;
      pc_q           <= RESET_IDX;
      out_valid_q    <= 1'b0;
      out_instr_q    <= '0;
      out_pc_q       <= '0;
      out_pc_plus1_q <= '0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      out_valid_q    <= out_valid_d;
      out_instr_q    <= out_instr_d;
      out_pc_q       <= out_pc_d;
      out_pc_plus1_q <= out_pc_plus1_d;
    end
  end

  assign imem_index   = pc_q;
  assign out_valid    = out_valid_q;
  assign out_instr    = out_instr_q;
  assign out_pc       = out_pc_q;
  assign out_pc_plus1 = out_pc_plus1_q;

endmodule

// File: tb/tb_instr_fetch.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch
// Directed scenarios followed by a randomized run, all checked against a
// stream-level reference model of the fetch stage.
// ---------------------------------------------------------------------------
module tb_instr_fetch;

  localparam int DEPTH    = 16;
  localparam int RESET_PC = 0;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = 32'd0;
  logic        out_ready = 1'b0;
  logic [31:0] imem_index;
  logic [31:0] imem_instr;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_pc_plus1;

  logic [31:0] mem [DEPTH];

  int total = 0;
  int bad   = 0;

  // Reference model: where the next fetch comes from, whether the stage has
  // left its start-up cycle, and the entry currently offered downstream.
  bit          mStarted = 1'b0;
  bit          mHeld    = 1'b0;
  int unsigned mPc      = 0;
  logic [31:0] mInstr   = 32'd0;
  int unsigned mOutPc   = 0;
  int unsigned mPlus1   = 0;

  always #5 clk = ~clk;

  // Instruction memory answers combinationally from the presented index.
  assign imem_instr = mem[imem_index[3:0]];

  instr_fetch #(
    .IMEM_DEPTH (DEPTH),
    .RESET_PC   (RESET_PC)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .imem_index      (imem_index),
    .imem_instr      (imem_instr),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_instr       (out_instr),
    .out_pc          (out_pc),
    .out_pc_plus1    (out_pc_plus1)
  );

  // One comparison: counts it, and reports it when it does not hold.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("[TB] FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Drives all inputs; called just after a rising edge.
  task automatic applyStimulus(input logic rst, input logic rv, input logic [31:0] rt,
                               input logic rdy);
    reset           = rst;
    redirect_valid  = rv;
    redirect_target = rt;
    out_ready       = rdy;
  endtask

  // What one clock edge does to the instruction stream, in program terms.
  task automatic modelEdge();
    logic [31:0] fetched;
    if (reset) begin
      mPc      = RESET_PC % DEPTH;
      mStarted = 1'b0;
      mHeld    = 1'b0;
      mInstr   = 32'd0;
      mOutPc   = 0;
      mPlus1   = 0;
    end else if (redirect_valid) begin
      mPc      = redirect_target % DEPTH;
      mHeld    = 1'b0;
      mStarted = 1'b1;
    end else if (!mStarted) begin
      mStarted = 1'b1;
    end else if (!mHeld || out_ready) begin
      fetched = mem[mPc];
      mInstr  = fetched;
      mOutPc  = mPc;
      mPlus1  = (mPc + 1) % DEPTH;
      mHeld   = 1'b1;
      if (fetched[31:26] == 6'b000010)
        mPc = fetched[25:0] % DEPTH;
      else
        mPc = (mPc + 1) % DEPTH;
    end
  endtask

  // Compares every output against the model.
  task automatic checkOutput();
    check("out_valid", {31'b0, out_valid}, {31'b0, mHeld});
    check("imem_index", imem_index, mPc);
    check("out_instr", out_instr, mInstr);
    check("out_pc", out_pc, mOutPc);
    check("out_pc_plus1", out_pc_plus1, mPlus1);
  endtask

  // Advances one clock, updates the model, then samples the DUT.
  task automatic tick();
    @(posedge clk);
    modelEdge();
    #1;
    checkOutput();
  endtask

  // Reset followed by the start-up cycle and the first capture.
  task automatic startup();
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
    tick();
    tick();
  endtask

  // Directed scenarios, then a randomized run with occasional resets and
  // redirects and random downstream back-pressure.
  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'h2000_0000 | i;
    mem[8] = 32'h0800_0000;

    $display("[TB] reset values");
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b1);
    tick();
    tick();
    check("rst_valid", {31'b0, out_valid}, 32'd0);
    check("rst_instr", out_instr, 32'd0);
    check("rst_pc", out_pc, 32'd0);
    check("rst_pc_plus1", out_pc_plus1, 32'd0);
    check("rst_index", imem_index, 32'd0);

    $display("[TB] start-up latency and jump loop");
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
    tick();
    check("start_no_valid", {31'b0, out_valid}, 32'd0);
    tick();
    check("first_valid", {31'b0, out_valid}, 32'd1);
    check("first_pc", out_pc, 32'd0);
    for (int k = 1; k <= 11; k++) begin
      tick();
      check("jloop_valid", {31'b0, out_valid}, 32'd1);
      check("jloop_pc", out_pc, (k <= 8) ? k : k - 9);
    end

    $display("[TB] stall hold");
    mem[2] = 32'h8CC4_0001;
    startup();
    tick();
    tick();
    check("stall_pre_pc", out_pc, 32'd2);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("stall_instr", out_instr, 32'h8CC4_0001);
      check("stall_pc", out_pc, 32'd2);
      check("stall_index", imem_index, 32'd3);
    end
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
    tick();
    check("stall_release_pc", out_pc, 32'd3);

    $display("[TB] redirect with held entry");
    startup();
    repeat (6) tick();
    check("redir_pre_pc", out_pc, 32'd6);
    applyStimulus(1'b0, 1'b1, 32'd5, 1'b1);
    tick();
    check("redir_valid", {31'b0, out_valid}, 32'd0);
    check("redir_index", imem_index, 32'd5);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
    tick();
    check("redir_pc", out_pc, 32'd5);

    $display("[TB] index wrap and target masking");
    mem[8] = 32'h2000_0008;
    startup();
    repeat (15) tick();
    check("wrap_pc15", out_pc, 32'd15);
    check("wrap_plus1", out_pc_plus1, 32'd0);
    tick();
    check("wrap_pc0", out_pc, 32'd0);
    applyStimulus(1'b0, 1'b1, 32'h13, 1'b1);
    tick();
    check("mask_index", imem_index, 32'd3);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
    tick();
    check("mask_pc", out_pc, 32'd3);

    $display("[TB] reset during stall");
    startup();
    repeat (4) tick();
    check("rststall_pre_pc", out_pc, 32'd4);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);
    tick();
    tick();
    check("rststall_hold_pc", out_pc, 32'd4);
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0);
    tick();
    check("rststall_valid", {31'b0, out_valid}, 32'd0);
    check("rststall_index", imem_index, 32'd0);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
    tick();
    tick();
    check("rststall_first_valid", {31'b0, out_valid}, 32'd1);
    check("rststall_first_pc", out_pc, 32'd0);

    $display("[TB] redirect beats jump");
    mem[3] = 32'h0800_0000;
    startup();
    tick();
    tick();
    check("rj_index", imem_index, 32'd3);
    applyStimulus(1'b0, 1'b1, 32'd7, 1'b1);
    tick();
    check("rj_pc_loaded", imem_index, 32'd7);
    check("rj_valid", {31'b0, out_valid}, 32'd0);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
    tick();
    check("rj_next_pc", out_pc, 32'd7);

    $display("[TB] randomized run");
    for (int i = 0; i < DEPTH; i++) begin
      if ($urandom_range(3) == 0)
        mem[i] = {6'b000010, 26'($urandom)};
      else
        mem[i] = {6'b100011, 26'($urandom)};
    end
    for (int cyc = 0; cyc < 2000; cyc++) begin
      int r;
      r = $urandom_range(99);
      applyStimulus(r < 2, (r >= 2) && (r < 10), $urandom, $urandom_range(3) != 0);
      tick();
    end

    applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
